// File: rtl/pc_update_ctrl.sv
// pc_update_ctrl: multicycle PC-update sequencer for beq/bne/ble/bgt/j/jal/jr.
// Define PC_BRANCH_STATS_EN to add saturating taken/not-taken branch counters.
module pc_update_ctrl #(
    parameter int unsigned OPW     = 6,
    parameter int unsigned CMP_LAT = 1
`ifdef PC_BRANCH_STATS_EN
    ,
    parameter int unsigned CNT_W   = 16
`endif
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           instr_valid,
    output logic           instr_ready,
    input  logic [OPW-1:0] opcode,
    input  logic [OPW-1:0] funct,
    input  logic           zero,
    input  logic           gt,
    input  logic           flush,
    output logic           alu_cmp,
    output logic           pc_write,
    output logic [1:0]     pc_src,
    output logic           ra_write,
    output logic           done,
    output logic           bad_op
`ifdef PC_BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] taken_cnt,
    output logic [CNT_W-1:0] ntaken_cnt,
    input  logic             stats_clr
`endif
);
    localparam int unsigned WAIT_W = 3;

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(8'h00);
    localparam logic [OPW-1:0] OP_J     = OPW'(8'h02);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(8'h03);
    localparam logic [OPW-1:0] OP_BEQ   = OPW'(8'h04);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(8'h05);
    localparam logic [OPW-1:0] OP_BLE   = OPW'(8'h06);
    localparam logic [OPW-1:0] OP_BGT   = OPW'(8'h07);
    localparam logic [OPW-1:0] FN_JR    = OPW'(8'h08);

    typedef enum logic [2:0] {S_IDLE, S_CMP, S_EVAL, S_WRITE, S_DONE} state_t;
    typedef enum logic [1:0] {K_ILL, K_BR, K_JMP} kind_t;

    function automatic kind_t decode(input logic [OPW-1:0] op, input logic [OPW-1:0] fn);
        if (op == OP_BEQ || op == OP_BNE || op == OP_BLE || op == OP_BGT) return K_BR;
        if (op == OP_J || op == OP_JAL || (op == OP_RTYPE && fn == FN_JR)) return K_JMP;
        return K_ILL;
    endfunction

    function automatic logic br_taken(input logic [OPW-1:0] op, input logic z, input logic g);
        if (op == OP_BEQ) return z;
        if (op == OP_BNE) return !z;
        if (op == OP_BLE) return !g;
        return g;
    endfunction

    state_t            r_state, w_state_nxt;
    logic [WAIT_W-1:0] r_wait, w_wait_nxt;
    logic              r_taken, w_taken_nxt;
    logic [OPW-1:0]    r_opcode, w_opcode_nxt;
    logic [OPW-1:0]    r_funct, w_funct_nxt;
    logic              r_instr_ready, w_instr_ready;
    logic              r_alu_cmp, w_alu_cmp;
    logic              r_pc_write, w_pc_write;
    logic [1:0]        r_pc_src, w_pc_src;
    logic              r_ra_write, w_ra_write;
    logic              r_done, w_done;
    logic              r_bad_op, w_bad_op;
    kind_t             w_kind_nxt;

    // Next state, then outputs derived from the next state so they register with it.
    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait;
        w_taken_nxt   = r_taken;
        w_opcode_nxt  = r_opcode;
        w_funct_nxt   = r_funct;
        w_instr_ready = 1'b0;
        w_alu_cmp     = 1'b0;
        w_pc_write    = 1'b0;
        w_pc_src      = 2'b00;
        w_ra_write    = 1'b0;
        w_done        = 1'b0;
        w_bad_op      = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (instr_valid) begin
                    w_opcode_nxt = opcode;
                    w_funct_nxt  = funct;
                    w_taken_nxt  = 1'b0;
                    case (decode(opcode, funct))
                        K_BR: begin
                            w_state_nxt = S_CMP;
                            w_wait_nxt  = WAIT_W'(CMP_LAT - 1);
                        end
                        K_JMP:   w_state_nxt = S_WRITE;
                        default: w_state_nxt = S_DONE;
                    endcase
                end
            end
            S_CMP: begin
                if (r_wait == '0) w_state_nxt = S_EVAL;
                else              w_wait_nxt  = r_wait - WAIT_W'(1);
            end
            S_EVAL: begin
                w_taken_nxt = br_taken(r_opcode, zero, gt);
                w_state_nxt = S_WRITE;
            end
            S_WRITE: w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase

        // Abort overrides every transition, including a same-cycle accept.
        if (flush) w_state_nxt = S_IDLE;

        w_kind_nxt = decode(w_opcode_nxt, w_funct_nxt);
        case (w_state_nxt)
            S_IDLE:        w_instr_ready = 1'b1;
            S_CMP, S_EVAL: w_alu_cmp     = 1'b1;
            S_WRITE: begin
                if (w_kind_nxt == K_BR) begin
                    w_pc_write = w_taken_nxt;
                    w_pc_src   = w_taken_nxt ? 2'b01 : 2'b00;
                end else begin
                    w_pc_write = 1'b1;
                    w_pc_src   = (w_opcode_nxt == OP_RTYPE) ? 2'b11 : 2'b10;
                    w_ra_write = (w_opcode_nxt == OP_JAL);
                end
            end
            S_DONE: begin
                w_done   = 1'b1;
                w_bad_op = (w_kind_nxt == K_ILL);
            end
            default: w_instr_ready = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_wait        <= '0;
            r_taken       <= 1'b0;
            r_opcode      <= '0;
            r_funct       <= '0;
            r_instr_ready <= 1'b1;
            r_alu_cmp     <= 1'b0;
            r_pc_write    <= 1'b0;
            r_pc_src      <= 2'b00;
            r_ra_write    <= 1'b0;
            r_done        <= 1'b0;
            r_bad_op      <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wait        <= w_wait_nxt;
            r_taken       <= w_taken_nxt;
            r_opcode      <= w_opcode_nxt;
            r_funct       <= w_funct_nxt;
            r_instr_ready <= w_instr_ready;
            r_alu_cmp     <= w_alu_cmp;
            r_pc_write    <= w_pc_write;
            r_pc_src      <= w_pc_src;
            r_ra_write    <= w_ra_write;
            r_done        <= w_done;
            r_bad_op      <= w_bad_op;
        end
    end

    assign instr_ready = r_instr_ready;
    assign alu_cmp     = r_alu_cmp;
    assign pc_write    = r_pc_write;
    assign pc_src      = r_pc_src;
    assign ra_write    = r_ra_write;
    assign done        = r_done;
    assign bad_op      = r_bad_op;

`ifdef PC_BRANCH_STATS_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] r_taken_cnt;
    logic [CNT_W-1:0] r_ntaken_cnt;
    logic             w_br_write;

    assign w_br_write = (r_state == S_WRITE) && (decode(r_opcode, r_funct) == K_BR);

    // Saturating outcome counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_taken_cnt  <= '0;
            r_ntaken_cnt <= '0;
        end else if (stats_clr) begin
            r_taken_cnt  <= '0;
            r_ntaken_cnt <= '0;
        end else if (w_br_write) begin
            if (r_taken && r_taken_cnt != CNT_MAX)
                r_taken_cnt <= r_taken_cnt + CNT_W'(1);
            if (!r_taken && r_ntaken_cnt != CNT_MAX)
                r_ntaken_cnt <= r_ntaken_cnt + CNT_W'(1);
        end
    end

    assign taken_cnt  = r_taken_cnt;
    assign ntaken_cnt = r_ntaken_cnt;
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// Bench for pc_update_ctrl: timeline-based reference model, directed cases with
// literal expectations, then randomized traffic. Honours PC_BRANCH_STATS_EN.
module tb_pc_update_ctrl;
    localparam int unsigned OPW     = 6;
    localparam int unsigned CMP_LAT = 2;
    localparam int unsigned CNT_W   = 3;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           instr_valid = 1'b0;
    logic [OPW-1:0] opcode = '0;
    logic [OPW-1:0] funct = '0;
    logic           zero = 1'b0;
    logic           gt = 1'b0;
    logic           flush = 1'b0;
    logic           stats_clr = 1'b0;
    logic           instr_ready, alu_cmp, pc_write, ra_write, done, bad_op;
    logic [1:0]     pc_src;
`ifdef PC_BRANCH_STATS_EN
    logic [CNT_W-1:0] taken_cnt, ntaken_cnt;
`endif

    always #5 clk = ~clk;

    pc_update_ctrl #(
        .OPW(OPW), .CMP_LAT(CMP_LAT)
`ifdef PC_BRANCH_STATS_EN
        , .CNT_W(CNT_W)
`endif
    ) dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .opcode(opcode), .funct(funct), .zero(zero), .gt(gt), .flush(flush),
        .alu_cmp(alu_cmp), .pc_write(pc_write), .pc_src(pc_src), .ra_write(ra_write),
        .done(done), .bad_op(bad_op)
`ifdef PC_BRANCH_STATS_EN
        , .taken_cnt(taken_cnt), .ntaken_cnt(ntaken_cnt), .stats_clr(stats_clr)
`endif
    );

    // One expected output cycle; smp marks the flag-sampling cycle, brw a branch write cycle.
    typedef struct packed {
        logic           ready, cmp, pcw;
        logic [1:0]     src;
        logic           ra, dn, bad, smp, brw;
        logic [OPW-1:0] op;
    } exp_t;

    exp_t        cur;
    exp_t        plan[$];
    int unsigned tc, nc;
    int          n_cmp = 0;
    int          n_bad = 0;

    function automatic exp_t idle_e();
        exp_t e = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    task automatic model_reset();
        plan.delete();
        cur = idle_e();
        tc  = 0;
        nc  = 0;
    endtask

    // Build the whole output timeline of an accepted instruction.
    task automatic accept(input logic [OPW-1:0] op, input logic [OPW-1:0] fn);
        exp_t e;
        if (op >= 4 && op <= 7) begin
            for (int i = 0; i < int'(CMP_LAT); i++) begin
                e = '0; e.cmp = 1'b1; plan.push_back(e);
            end
            e = '0; e.cmp = 1'b1; e.smp = 1'b1; e.op = op; plan.push_back(e);
            e = '0; e.brw = 1'b1; plan.push_back(e);
            e = '0; e.dn = 1'b1; plan.push_back(e);
        end else if (op == 2 || op == 3 || (op == 0 && fn == 8)) begin
            e = '0; e.pcw = 1'b1; e.src = (op == 0) ? 2'd3 : 2'd2; e.ra = (op == 3);
            plan.push_back(e);
            e = '0; e.dn = 1'b1; plan.push_back(e);
        end else begin
            e = '0; e.dn = 1'b1; e.bad = 1'b1; plan.push_back(e);
        end
    endtask

    task automatic model_step(input logic v, input logic [OPW-1:0] op, input logic [OPW-1:0] fn,
                              input logic z, input logic g, input logic fl, input logic clr);
        exp_t nxt;
        logic t;
        if (clr) begin
            tc = 0; nc = 0;
        end else if (cur.brw) begin
            if (cur.pcw) begin if (tc < CNT_MAX) tc++; end
            else         begin if (nc < CNT_MAX) nc++; end
        end
        if (fl) begin
            plan.delete();
            nxt = idle_e();
        end else if (cur.ready && v) begin
            accept(op, fn);
            nxt = plan.pop_front();
        end else if (plan.size() > 0) begin
            nxt = plan.pop_front();
            if (cur.smp) begin
                case (cur.op)
                    6'h04:   t = z;
                    6'h05:   t = !z;
                    6'h06:   t = !g;
                    default: t = g;
                endcase
                nxt.pcw = t;
                nxt.src = t ? 2'd1 : 2'd0;
            end
        end else begin
            nxt = idle_e();
        end
        cur = nxt;
    endtask

    task automatic check_all();
        chk("instr_ready", instr_ready, cur.ready);
        chk("alu_cmp", alu_cmp, cur.cmp);
        chk("pc_write", pc_write, cur.pcw);
        chk("pc_src", pc_src, cur.src);
        chk("ra_write", ra_write, cur.ra);
        chk("done", done, cur.dn);
        chk("bad_op", bad_op, cur.bad);
`ifdef PC_BRANCH_STATS_EN
        chk("taken_cnt", taken_cnt, tc);
        chk("ntaken_cnt", ntaken_cnt, nc);
`endif
    endtask

    task automatic tick(input logic v, input logic [OPW-1:0] op, input logic [OPW-1:0] fn,
                        input logic z, input logic g, input logic fl, input logic clr);
        instr_valid = v; opcode = op; funct = fn; zero = z; gt = g; flush = fl; stats_clr = clr;
        model_step(v, op, fn, z, g, fl, clr);
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle_tick();
        tick(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Accept at cycle 0, keep offering junk while busy; report pc_write/done cycles.
    task automatic run_op(input logic [OPW-1:0] op, input logic [OPW-1:0] fn, input logic z,
                          input logic g, input logic clr, output int wc, output int dc,
                          output logic [1:0] src, output logic ra, output logic bad);
        int k;
        wc = 0; dc = 0; src = 2'd0; ra = 1'b0; bad = 1'b0;
        tick(1'b1, op, fn, z, g, 1'b0, 1'b0);
        k = 1;
        while (dc == 0 && k <= 12) begin
            if (pc_write === 1'b1) begin wc = k; src = pc_src; ra = ra_write; end
            if (done === 1'b1) begin
                dc = k; bad = bad_op;
            end else begin
                tick(1'b1, OPW'($urandom), OPW'($urandom), z, g, 1'b0,
                     clr && (k == int'(CMP_LAT) + 2));
                k++;
            end
        end
    endtask

    initial begin
        int wc, dc;
        logic [1:0] src;
        logic ra, bad;
        logic [OPW-1:0] ops[9];
        logic v, fl, clr;
        logic [OPW-1:0] op, fn;
        ops = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h23, 6'h00};

        #1 reset = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        chk("reset_ready", instr_ready, 1);
        chk("reset_pc_write", pc_write, 0);
        reset = 1'b1;
        idle_tick();

        run_op(6'h04, 6'h00, 1'b1, 1'b0, 1'b0, wc, dc, src, ra, bad);
        chk("beq_write_cycle", wc, 4);
        chk("beq_pc_src", src, 1);
        chk("beq_done_cycle", dc, 5);
        chk("beq_bad_op", bad, 0);
        idle_tick();

        run_op(6'h05, 6'h00, 1'b1, 1'b0, 1'b0, wc, dc, src, ra, bad);
        chk("bne_no_write", wc, 0);
        chk("bne_done_cycle", dc, 5);
        chk("bne_bad_op", bad, 0);
        idle_tick();
`ifdef PC_BRANCH_STATS_EN
        chk("bne_ntaken_lit", ntaken_cnt, 1);
`endif

        run_op(6'h03, 6'h00, 1'b0, 1'b0, 1'b0, wc, dc, src, ra, bad);
        chk("jal_write_cycle", wc, 1);
        chk("jal_ra_write", ra, 1);
        chk("jal_pc_src", src, 2);
        chk("jal_done_cycle", dc, 2);
        idle_tick();

        run_op(6'h00, 6'h08, 1'b0, 1'b0, 1'b0, wc, dc, src, ra, bad);
        chk("jr_write_cycle", wc, 1);
        chk("jr_pc_src", src, 3);
        chk("jr_ra_write", ra, 0);
        idle_tick();

        run_op(6'h23, 6'h00, 1'b0, 1'b0, 1'b0, wc, dc, src, ra, bad);
        chk("illegal_no_write", wc, 0);
        chk("illegal_done_cycle", dc, 1);
        chk("illegal_bad_op", bad, 1);
        idle_tick();

        tick(1'b1, 6'h07, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("flush_ready", instr_ready, 1);
        chk("flush_alu_cmp", alu_cmp, 0);
        repeat (4) idle_tick();

        tick(1'b1, 6'h07, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 6'h00, 6'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("eval_alu_cmp", alu_cmp, 1);
        #2 reset = 1'b0;
        #1;
        chk("rst_mid_alu_cmp", alu_cmp, 0);
        chk("rst_mid_pc_write", pc_write, 0);
        chk("rst_mid_ready", instr_ready, 1);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        check_all();
        repeat (3) idle_tick();

`ifdef PC_BRANCH_STATS_EN
        for (int i = 0; i < 9; i++) begin
            run_op(6'h07, 6'h00, 1'b0, 1'b1, 1'b0, wc, dc, src, ra, bad);
            idle_tick();
        end
        chk("taken_saturated", taken_cnt, CNT_MAX);
        run_op(6'h07, 6'h00, 1'b0, 1'b1, 1'b1, wc, dc, src, ra, bad);
        idle_tick();
        chk("clear_beats_inc", taken_cnt, 0);
`endif

        for (int i = 0; i < 3000; i++) begin
            v   = 1'($urandom_range(0, 1));
            op  = ops[$urandom_range(0, 8)];
            if ($urandom_range(0, 7) == 0) op = OPW'($urandom);
            fn  = ($urandom_range(0, 1) == 1) ? 6'h08 : OPW'($urandom);
            fl  = (cur.ready || cur.cmp) && ($urandom_range(0, 15) == 0);
            clr = ($urandom_range(0, 31) == 0);
            tick(v, op, fn, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), fl, clr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
